// File: rtl/xpb_pkg.sv
// Shared defaults and state encoding for the reduction-table writer and its helpers.
package xpb_pkg;

  localparam int XPB_WIDTH    = 1024;
  localparam int XPB_IDX_BITS = 5;
  localparam int XPB_ENTRIES  = 1 << XPB_IDX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    STEP,
    DONE
  } xpb_state_e;

endpackage

// File: rtl/xpb_table_writer_if.sv
// Table write port: one entry per valid/ready transfer into the reduction-table RAM.
interface xpb_table_writer_if #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5
) ();

  logic                wr_valid;
  logic                wr_ready;
  logic [IDX_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/xpb_mod_add.sv
// Combinational (a + b) mod n for operands already reduced below n.
module xpb_mod_add #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  // sum < 2n, so the trial difference always fits in WIDTH bits when taken
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = sum[WIDTH-1:0] - n;
  assign y    = (sum >= {1'b0, n}) ? diff : sum[WIDTH-1:0];

endmodule

// File: rtl/xpb_table_writer.sv
// Generates j*B mod N for every table index by repeated modular addition and
// streams each entry out over the write handshake.
module xpb_table_writer
  import xpb_pkg::*;
#(
  parameter int WIDTH    = XPB_WIDTH,
  parameter int IDX_BITS = XPB_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [WIDTH-1:0]      base,
  output logic                  busy,
  output logic                  done,
  xpb_table_writer_if.master    wr
);

  xpb_state_e          state_q, state_d;
  logic [WIDTH-1:0]    n_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    acc_q;
  logic [WIDTH-1:0]    acc_next;
  logic [IDX_BITS-1:0] idx_q;
  logic                accept;
  logic                xfer;
  logic                last_idx;

  assign accept   = (state_q == IDLE) && start;
  assign xfer     = (state_q == EMIT) && wr.wr_ready;
  assign last_idx = &idx_q;

  xpb_mod_add #(.WIDTH(WIDTH)) u_mod_add (
    .a (acc_q),
    .b (b_q),
    .n (n_q),
    .y (acc_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EMIT;
      EMIT:    if (wr.wr_ready) state_d = last_idx ? DONE : STEP;
      STEP:    state_d = EMIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // acc/idx are cleared on leaving the last EMIT so DONE and IDLE drive zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept || (xfer && last_idx)) begin
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == STEP) begin
        acc_q <= acc_next;
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Operands are only meaningful after an accepted start, so they carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      n_q <= modulus;
      b_q <= base;
    end
  end

  assign wr.wr_valid = (state_q == EMIT);
  assign wr.wr_addr  = idx_q;
  assign wr.wr_data  = acc_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_xpb_table_writer.sv
// Directed/randomized bench for xpb_table_writer against an arithmetic j*B mod N model.
module tb_xpb_table_writer;
  import xpb_pkg::*;

  localparam int WIDTH    = XPB_WIDTH;
  localparam int IDX_BITS = XPB_IDX_BITS;
  localparam int ENTRIES  = XPB_ENTRIES;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] base;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  xpb_table_writer_if #(.WIDTH(WIDTH), .IDX_BITS(IDX_BITS)) wr ();

  xpb_table_writer #(.WIDTH(WIDTH), .IDX_BITS(IDX_BITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .modulus (modulus),
    .base    (base),
    .busy    (busy),
    .done    (done),
    .wr      (wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs[191:0], exp[191:0]);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_modulus();
    logic [WIDTH-1:0] r;
    r = rand_wide();
    r[WIDTH-1] = 1'b1;
    r[0] = 1'b1;
    return r;
  endfunction

  // Reference: entry j is the plain product j*B reduced mod N
  function automatic logic [WIDTH-1:0] model(input int j, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] n);
    logic [WIDTH+IDX_BITS:0] prod;
    logic [WIDTH+IDX_BITS:0] nn;
    prod = (WIDTH+IDX_BITS+1)'(b) * (WIDTH+IDX_BITS+1)'(j);
    nn   = (WIDTH+IDX_BITS+1)'(n);
    return WIDTH'(prod % nn);
  endfunction

  task automatic run_table(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] b,
                           input int ready_pct, input int abort_idx, input bit ign_test);
    int                  exp13[14] = '{0, 5, 10, 2, 7, 12, 4, 9, 1, 6, 11, 3, 8, 0};
    int                  nxt = 0;
    int                  cyc = 0;
    int                  last_xfer = -1;
    bit                  prev_hold = 1'b0;
    bit                  fin = 1'b0;
    bit                  aborted = 1'b0;
    logic [IDX_BITS-1:0] prev_addr = '0;
    logic [WIDTH-1:0]    prev_data = '0;
    modulus  = n;
    base     = b;
    start    = 1'b1;
    wr.wr_ready = (ready_pct >= 100);
    @(posedge clk);
    while (!fin && !aborted && cyc < 4000) begin
      @(negedge clk);
      start = ign_test && ((cyc + 1 == 5) || (cyc + 1 == 64));
      if (ign_test && cyc == 0) begin
        modulus = rand_modulus();
        base    = rand_wide();
      end
      check("busy_run", WIDTH'(busy), WIDTH'(1));
      if (prev_hold) begin
        check("hold_valid", WIDTH'(wr.wr_valid), WIDTH'(1));
        check("hold_addr", WIDTH'(wr.wr_addr), WIDTH'(prev_addr));
        check("hold_data", wr.wr_data, prev_data);
      end
      if (done) begin
        check("xfer_count", WIDTH'(nxt), WIDTH'(ENTRIES));
        check("done_after_last", WIDTH'(cyc + 1), WIDTH'(last_xfer + 1));
        if (ready_pct >= 100) check("done_cycle", WIDTH'(cyc + 1), WIDTH'(2 * ENTRIES));
        fin = 1'b1;
      end else if (wr.wr_valid && abort_idx >= 0 && int'(wr.wr_addr) == abort_idx) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", WIDTH'(busy), WIDTH'(0));
        check("rst_done", WIDTH'(done), WIDTH'(0));
        check("rst_valid", WIDTH'(wr.wr_valid), WIDTH'(0));
        check("rst_addr", WIDTH'(wr.wr_addr), WIDTH'(0));
        check("rst_data", wr.wr_data, WIDTH'(0));
        wr.wr_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("rst_no_done", WIDTH'(done), WIDTH'(0));
          check("rst_idle", WIDTH'(busy), WIDTH'(0));
        end
        rst_n   = 1'b1;
        aborted = 1'b1;
      end else if (wr.wr_valid) begin
        check("addr_order", WIDTH'(wr.wr_addr), WIDTH'(nxt));
        check("entry_data", wr.wr_data, model(nxt, b, n));
        if (n == WIDTH'(13) && b == WIDTH'(5) && nxt < 14)
          check("small_table", wr.wr_data, WIDTH'(exp13[nxt]));
        if (nxt == 1) check("entry1_is_base", wr.wr_data, b);
        wr.wr_ready = ($urandom_range(0, 99) < ready_pct);
        if (wr.wr_ready) begin
          if (ready_pct >= 100) check("xfer_cycle", WIDTH'(cyc + 1), WIDTH'(2 * nxt + 1));
          nxt++;
          last_xfer = cyc + 1;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_addr = wr.wr_addr;
          prev_data = wr.wr_data;
        end
      end else begin
        prev_hold = 1'b0;
        wr.wr_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (!fin && !aborted) begin
        @(posedge clk);
        cyc++;
      end
    end
    if (!aborted) begin
      check("done_seen", WIDTH'(fin), WIDTH'(1));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("post_busy", WIDTH'(busy), WIDTH'(0));
      check("post_done", WIDTH'(done), WIDTH'(0));
      check("post_valid", WIDTH'(wr.wr_valid), WIDTH'(0));
      check("post_data", wr.wr_data, WIDTH'(0));
    end
    start = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   p;
    rst_n       = 1'b0;
    start       = 1'b0;
    modulus     = '0;
    base        = '0;
    wr.wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", WIDTH'(busy), WIDTH'(0));
    check("reset_done", WIDTH'(done), WIDTH'(0));
    check("reset_valid", WIDTH'(wr.wr_valid), WIDTH'(0));
    check("reset_addr", WIDTH'(wr.wr_addr), WIDTH'(0));
    check("reset_data", wr.wr_data, WIDTH'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_table(WIDTH'(13), WIDTH'(5), 100, -1, 1'b0);

    n = rand_modulus();
    p = (WIDTH+1)'(1) << 760;
    b = WIDTH'(p % {1'b0, n});
    run_table(n, b, 100, -1, 1'b0);

    n = rand_modulus();
    b = rand_wide() % n;
    run_table(n, b, 50, -1, 1'b0);

    n = rand_modulus();
    b = rand_wide() % n;
    run_table(n, b, 100, 10, 1'b0);
    run_table(n, b, 60, -1, 1'b0);

    n = rand_modulus();
    b = rand_wide() % n;
    run_table(n, b, 100, -1, 1'b1);
    b = rand_wide() % n;
    run_table(n, b, 100, -1, 1'b0);

    n = rand_modulus();
    run_table(n, WIDTH'(0), 70, -1, 1'b0);
    run_table(n, n - WIDTH'(1), 100, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
